// File: rtl/pdp8_seq_pkg.sv
// Shared definitions for the PDP-8 major-state/phase sequencer: phase indices,
// decoder skip masks and the sequencer state type.
package pdp8_seq_pkg;

    typedef enum logic {
        StIdle,
        StRun
    } seq_state_e;

    localparam int unsigned PH_FETCH = 0;
    localparam int unsigned PH_AUTO1 = 1;
    localparam int unsigned PH_AUTO2 = 2;
    localparam int unsigned PH_IND   = 3;
    localparam int unsigned PH_EXEC1 = 4;
    localparam int unsigned PH_EXEC2 = 5;
    localparam int unsigned PH_EXEC3 = 6;
    localparam int unsigned PH_EXEC4 = 7;
    localparam int unsigned PH_EXEC5 = 8;
    localparam int unsigned PH_EXEC6 = 9;

    localparam int unsigned NPHASE_DEFAULT = 10;

    // Bit i set skips phase i; bit 0 (FETCH) is never skipped by the sequencer.
    localparam logic [NPHASE_DEFAULT-1:0] SKIP_DIRECT  = 10'b00_0000_1110;
    localparam logic [NPHASE_DEFAULT-1:0] SKIP_IND     = 10'b00_0000_0110;
    localparam logic [NPHASE_DEFAULT-1:0] SKIP_AUTOIND = 10'b00_0000_1000;

endpackage

// File: rtl/seq_debounce.sv
// Stability filter for the front-panel RUN switch: the output follows the input
// only after the input has held a new level for DEB_LIMIT consecutive cycles.
module seq_debounce #(
    parameter int unsigned DEB_LIMIT = 250000,
    parameter int unsigned DEB_W     = 18
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_raw,
    output logic o_level
);

    logic             r_level;
    logic [DEB_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else if (i_raw == r_level) begin
            r_cnt <= '0;
        end else if (r_cnt == DEB_W'(DEB_LIMIT - 1)) begin
            r_level <= i_raw;
            r_cnt   <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/phase_sequencer.sv
// Major-state/phase sequencer: walks the unmasked phases of each instruction,
// two ticks per phase, and drives the per-phase CK/STB clock enables.
module phase_sequencer
    import pdp8_seq_pkg::*;
#(
    parameter int unsigned NPHASE    = 10,
    parameter int unsigned PW        = 4,
    parameter int unsigned DEB_LIMIT = 250000,
    parameter int unsigned DEB_W     = 18
) (
    input  logic              i_sysclk,
    input  logic              i_reset,
    input  logic              i_run,
    input  logic              i_halt,
    input  logic              i_sstep,
    input  logic              i_done,
    input  logic [NPHASE-1:0] i_skip,
    output logic [NPHASE-1:0] o_ck,
    output logic [NPHASE-1:0] o_stb,
    output logic [PW-1:0]     o_phase,
    output logic              o_iend,
    output logic              o_running
);

    seq_state_e        r_state;
    seq_state_e        w_state_d;
    logic [PW-1:0]     r_phase;
    logic [PW-1:0]     w_phase_d;
    logic              r_tick;
    logic              w_tick_d;
    logic [NPHASE-1:0] r_mask;
    logic [NPHASE-1:0] w_mask_d;
    logic              r_halt_pend;
    logic              w_halt_pend_d;
    logic              r_iend;
    logic              w_iend_d;
    logic              r_run_prev;
    logic              r_halt_prev;

    logic              w_run_level;
    logic              w_run_edge;
    logic              w_halt_edge;
    logic              w_end;
    logic [NPHASE-1:0] w_mask_eff;
    logic [PW:0]       w_nxt;

    // Returns {found, index} of the lowest unmasked phase above cur.
    function automatic logic [PW:0] next_phase(input logic [NPHASE-1:0] mask,
                                               input logic [PW-1:0]     cur);
        logic [PW:0] res;
        res = '0;
        for (int i = NPHASE - 1; i > 0; i--) begin
            if (!mask[i] && (PW'(i) > cur)) begin
                res = {1'b1, PW'(i)};
            end
        end
        return res;
    endfunction

    seq_debounce #(
        .DEB_LIMIT (DEB_LIMIT),
        .DEB_W     (DEB_W)
    ) u_run_deb (
        .i_clk   (i_sysclk),
        .i_reset (i_reset),
        .i_raw   (i_run),
        .o_level (w_run_level)
    );

    assign w_run_edge  = w_run_level & ~r_run_prev;
    assign w_halt_edge = i_halt & ~r_halt_prev;

    always_ff @(posedge i_sysclk) begin
        if (i_reset) begin
            r_state     <= StIdle;
            r_phase     <= '0;
            r_tick      <= 1'b0;
            r_mask      <= '0;
            r_halt_pend <= 1'b0;
            r_iend      <= 1'b0;
            r_run_prev  <= 1'b0;
            r_halt_prev <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_phase     <= w_phase_d;
            r_tick      <= w_tick_d;
            r_mask      <= w_mask_d;
            r_halt_pend <= w_halt_pend_d;
            r_iend      <= w_iend_d;
            r_run_prev  <= w_run_level;
            r_halt_prev <= i_halt;
        end
    end

    always_comb begin
        w_state_d     = r_state;
        w_phase_d     = r_phase;
        w_tick_d      = r_tick;
        w_mask_d      = r_mask;
        w_halt_pend_d = r_halt_pend;
        w_iend_d      = 1'b0;
        w_end         = 1'b0;
        w_mask_eff    = r_mask;
        w_nxt         = '0;
        unique case (r_state)
            StIdle: begin
                // A simultaneous halt request suppresses the start.
                if (w_run_edge && !w_halt_edge) begin
                    w_state_d = StRun;
                    w_phase_d = '0;
                    w_tick_d  = 1'b0;
                end
            end
            StRun: begin
                if (w_halt_edge) begin
                    w_halt_pend_d = 1'b1;
                end
                if (i_done) begin
                    w_end = 1'b1;
                end else if (!r_tick) begin
                    w_tick_d = 1'b1;
                end else begin
                    if (r_phase == '0) begin
                        w_mask_eff = {i_skip[NPHASE-1:1], 1'b0};
                        w_mask_d   = w_mask_eff;
                    end
                    w_nxt = next_phase(w_mask_eff, r_phase);
                    if (w_nxt[PW]) begin
                        w_phase_d = w_nxt[PW-1:0];
                        w_tick_d  = 1'b0;
                    end else begin
                        w_end = 1'b1;
                    end
                end
                if (w_end) begin
                    w_iend_d      = 1'b1;
                    w_phase_d     = '0;
                    w_tick_d      = 1'b0;
                    w_halt_pend_d = 1'b0;
                    if (r_halt_pend || w_halt_edge || i_sstep) begin
                        w_state_d = StIdle;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        o_running = (r_state == StRun);
        o_phase   = r_phase;
        o_iend    = r_iend;
        for (int i = 0; i < NPHASE; i++) begin
            o_ck[i]  = o_running && (r_phase == PW'(i)) && !i_reset;
            o_stb[i] = o_ck[i] && r_tick;
        end
    end

endmodule
